// File: rtl/alu_result_wb.sv
// alu_result_wb: writeback stage behind the 32-bit ALU.
// Takes one ALU result per input handshake, keeps the {N,Z,C,V} flag
// register, buffers results in a small FIFO and drains them to the
// register-file write port. A multiply produces two beats (low word at rd,
// high word at rd+1). Every other op produces one beat.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. valid never depends on ready. While wb_valid
// is 1 and wb_ready is 0, wb_addr and wb_data hold their values.
module alu_result_wb #(
    parameter int DEPTH   = 2,
    parameter int RF_AW   = 5,
    parameter int R0_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [RF_AW-1:0] in_rd,
    input  logic [31:0]      in_out,
    input  logic [31:0]      in_out0,
    input  logic             in_n,
    input  logic             in_z,
    input  logic             in_c,
    input  logic             in_v,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RF_AW-1:0] wb_addr,
    output logic [31:0]      wb_data,
    output logic [3:0]       psw,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [RF_AW-1:0] ADDR_ONE = RF_AW'(1);

    localparam logic [3:0] OP_MUL = 4'b0011;

    // Output FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MUL_LO = 2'd1;
    localparam logic [1:0] ST_MUL_HI = 2'd2;
    localparam logic [1:0] ST_SINGLE = 2'd3;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [3:0]       q_op   [DEPTH];
    logic [RF_AW-1:0] q_rd   [DEPTH];
    logic [31:0]      q_out  [DEPTH];
    logic [31:0]      q_out0 [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [1:0]  state;
    logic [31:0] hi_word;   // multiply high word waiting for its beat

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic             accept;
    logic             op_legal;
    logic             push;
    logic             beat_done;
    logic             slot_free;
    logic             pop;
    logic [3:0]       head_op;
    logic [RF_AW-1:0] head_rd;
    logic [31:0]      head_out;
    logic [31:0]      head_out0;
    logic [RF_AW-1:0] hi_addr;

    // Beats addressed to index 0 are swallowed when R0_ZERO is set.
    function automatic logic suppress(input logic [RF_AW-1:0] addr);
        return (R0_ZERO != 0) && (addr == '0);
    endfunction

    // in_ready comes straight from the registered count: no bypass when full.
    assign in_ready = !rst && (count < CNT_FULL);

    assign accept   = in_valid && in_ready;
    assign op_legal = (in_op[3:2] == 2'b00);
    assign push     = accept && op_legal;

    // A pending beat finishes on a handshake, or immediately when it was
    // suppressed (wb_valid is only low outside IDLE for suppressed beats).
    assign beat_done = (state != ST_IDLE) && (!wb_valid || wb_ready);

    // The output register can take a new entry when idle, or when the last
    // beat of the current entry finishes this cycle (back-to-back beats).
    assign slot_free = (state == ST_IDLE) ||
                       (beat_done && ((state == ST_SINGLE) || (state == ST_MUL_HI)));
    assign pop       = (count != '0) && slot_free;

    assign head_op   = q_op[rd_ptr];
    assign head_rd   = q_rd[rd_ptr];
    assign head_out  = q_out[rd_ptr];
    assign head_out0 = q_out0[rd_ptr];

    // wb_addr holds rd during MUL_LO; the high beat goes to rd+1 (wraps).
    assign hi_addr = wb_addr + ADDR_ONE;

    assign busy      = (count != '0) || (state != ST_IDLE);
    assign dbg_state = state;

    // ------------------------------------------------------------------
    // FIFO storage write (data only, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= in_op;
            q_rd[wr_ptr]   <= in_rd;
            q_out[wr_ptr]  <= in_out;
            q_out0[wr_ptr] <= in_out0;
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave count alone
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Flag register: updated by every accepted legal op, illegal ops ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            psw <= 4'b0000;
        end else if (push) begin
            psw <= {in_n, in_z, in_c, in_v};
        end
    end

    // Output FSM: loads the head entry, sequences multiply halves, drives wb_*
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            hi_word  <= '0;
        end else if (pop) begin
            wb_addr  <= head_rd;
            wb_valid <= !suppress(head_rd);
            if (head_op == OP_MUL) begin
                state   <= ST_MUL_LO;
                wb_data <= head_out0;
                hi_word <= head_out;
            end else begin
                state   <= ST_SINGLE;
                wb_data <= head_out;
            end
        end else if (beat_done && (state == ST_MUL_LO)) begin
            state    <= ST_MUL_HI;
            wb_addr  <= hi_addr;
            wb_data  <= hi_word;
            wb_valid <= !suppress(hi_addr);
        end else if (beat_done) begin
            state    <= ST_IDLE;
            wb_valid <= 1'b0;
        end
    end

endmodule
